// File: rtl/iob_iob2axil.sv
// IOb subordinate to AXI-Lite manager bridge: replays one IOb request at a time
// as an AXI-Lite read or write; all outputs come straight from registers.
module iob_iob2axil #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    localparam int WSTRB_W = DATA_W / 8
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               arst_i,
    input  logic               iob_valid_i,
    input  logic [ADDR_W-1:0]  iob_addr_i,
    input  logic [DATA_W-1:0]  iob_wdata_i,
    input  logic [WSTRB_W-1:0] iob_wstrb_i,
    output logic               iob_ready_o,
    output logic               iob_rvalid_o,
    output logic [DATA_W-1:0]  iob_rdata_o,
    input  logic               iob_rready_i,
    output logic [ADDR_W-1:0]  axil_awaddr_o,
    output logic               axil_awvalid_o,
    input  logic               axil_awready_i,
    output logic [DATA_W-1:0]  axil_wdata_o,
    output logic [WSTRB_W-1:0] axil_wstrb_o,
    output logic               axil_wvalid_o,
    input  logic               axil_wready_i,
    input  logic [1:0]         axil_bresp_i,
    input  logic               axil_bvalid_i,
    output logic               axil_bready_o,
    output logic [ADDR_W-1:0]  axil_araddr_o,
    output logic               axil_arvalid_o,
    input  logic               axil_arready_i,
    input  logic [DATA_W-1:0]  axil_rdata_i,
    input  logic [1:0]         axil_rresp_i,
    input  logic               axil_rvalid_i,
    output logic               axil_rready_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W_AW  = 3'd1,
        W_B   = 3'd2,
        R_AR  = 3'd3,
        R_R   = 3'd4,
        R_RSP = 3'd5
    } state_t;

    state_t              r_state, w_state_n;
    logic [ADDR_W-1:0]   r_addr, w_addr_n;
    logic [DATA_W-1:0]   r_wdata, w_wdata_n;
    logic [WSTRB_W-1:0]  r_wstrb, w_wstrb_n;
    logic [DATA_W-1:0]   r_rdata, w_rdata_n;
    logic                r_iob_ready, w_iob_ready_n;
    logic                r_iob_rvalid, w_iob_rvalid_n;
    logic                r_awvalid, w_awvalid_n;
    logic                r_wvalid, w_wvalid_n;
    logic                r_bready, w_bready_n;
    logic                r_arvalid, w_arvalid_n;
    logic                r_rready, w_rready_n;
    logic                w_aw_done, w_w_done;

    // Response codes are deliberately dropped by this bridge.
    logic w_unused;
    assign w_unused = ^{axil_bresp_i, axil_rresp_i};

    // A write channel is done once its valid has been (or is now being) accepted.
    assign w_aw_done = !r_awvalid || axil_awready_i;
    assign w_w_done  = !r_wvalid  || axil_wready_i;

    always_comb begin
        w_state_n      = r_state;
        w_addr_n       = r_addr;
        w_wdata_n      = r_wdata;
        w_wstrb_n      = r_wstrb;
        w_rdata_n      = r_rdata;
        w_iob_ready_n  = 1'b0;
        w_iob_rvalid_n = r_iob_rvalid;
        w_awvalid_n    = r_awvalid;
        w_wvalid_n     = r_wvalid;
        w_bready_n     = r_bready;
        w_arvalid_n    = r_arvalid;
        w_rready_n     = r_rready;
        case (r_state)
            IDLE: begin
                if (iob_valid_i) begin
                    w_iob_ready_n = 1'b1;
                    w_addr_n      = iob_addr_i;
                    if (iob_wstrb_i != '0) begin
                        w_wdata_n   = iob_wdata_i;
                        w_wstrb_n   = iob_wstrb_i;
                        w_awvalid_n = 1'b1;
                        w_wvalid_n  = 1'b1;
                        w_state_n   = W_AW;
                    end else begin
                        w_arvalid_n = 1'b1;
                        w_state_n   = R_AR;
                    end
                end
            end
            W_AW: begin
                if (r_awvalid && axil_awready_i) w_awvalid_n = 1'b0;
                if (r_wvalid && axil_wready_i)   w_wvalid_n  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready_n = 1'b1;
                    w_state_n  = W_B;
                end
            end
            W_B: begin
                if (axil_bvalid_i) begin
                    w_bready_n = 1'b0;
                    w_state_n  = IDLE;
                end
            end
            R_AR: begin
                if (axil_arready_i) begin
                    w_arvalid_n = 1'b0;
                    w_rready_n  = 1'b1;
                    w_state_n   = R_R;
                end
            end
            R_R: begin
                if (axil_rvalid_i) begin
                    w_rready_n     = 1'b0;
                    w_rdata_n      = axil_rdata_i;
                    w_iob_rvalid_n = 1'b1;
                    w_state_n      = R_RSP;
                end
            end
            R_RSP: begin
                if (iob_rready_i) begin
                    w_iob_rvalid_n = 1'b0;
                    w_state_n      = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_iob_ready  <= 1'b0;
            r_iob_rvalid <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
        end else if (cke_i) begin
            r_state      <= w_state_n;
            r_addr       <= w_addr_n;
            r_wdata      <= w_wdata_n;
            r_wstrb      <= w_wstrb_n;
            r_rdata      <= w_rdata_n;
            r_iob_ready  <= w_iob_ready_n;
            r_iob_rvalid <= w_iob_rvalid_n;
            r_awvalid    <= w_awvalid_n;
            r_wvalid     <= w_wvalid_n;
            r_bready     <= w_bready_n;
            r_arvalid    <= w_arvalid_n;
            r_rready     <= w_rready_n;
        end
    end

    assign iob_ready_o    = r_iob_ready;
    assign iob_rvalid_o   = r_iob_rvalid;
    assign iob_rdata_o    = r_rdata;
    assign axil_awaddr_o  = r_addr;
    assign axil_araddr_o  = r_addr;
    assign axil_awvalid_o = r_awvalid;
    assign axil_wdata_o   = r_wdata;
    assign axil_wstrb_o   = r_wstrb;
    assign axil_wvalid_o  = r_wvalid;
    assign axil_bready_o  = r_bready;
    assign axil_arvalid_o = r_arvalid;
    assign axil_rready_o  = r_rready;

endmodule

// File: tb/tb_iob_iob2axil.sv
// Directed bench for iob_iob2axil: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values.
module tb_iob_iob2axil;

    localparam int ADDR_W  = 21;
    localparam int DATA_W  = 32;
    localparam int WSTRB_W = DATA_W / 8;

    logic               clk_i = 1'b0;
    logic               cke_i = 1'b1;
    logic               arst_i = 1'b0;
    logic               iob_valid_i = 1'b0;
    logic [ADDR_W-1:0]  iob_addr_i = '0;
    logic [DATA_W-1:0]  iob_wdata_i = '0;
    logic [WSTRB_W-1:0] iob_wstrb_i = '0;
    logic               iob_ready_o;
    logic               iob_rvalid_o;
    logic [DATA_W-1:0]  iob_rdata_o;
    logic               iob_rready_i = 1'b0;
    logic [ADDR_W-1:0]  axil_awaddr_o;
    logic               axil_awvalid_o;
    logic               axil_awready_i = 1'b0;
    logic [DATA_W-1:0]  axil_wdata_o;
    logic [WSTRB_W-1:0] axil_wstrb_o;
    logic               axil_wvalid_o;
    logic               axil_wready_i = 1'b0;
    logic [1:0]         axil_bresp_i = 2'b00;
    logic               axil_bvalid_i = 1'b0;
    logic               axil_bready_o;
    logic [ADDR_W-1:0]  axil_araddr_o;
    logic               axil_arvalid_o;
    logic               axil_arready_i = 1'b0;
    logic [DATA_W-1:0]  axil_rdata_i = '0;
    logic [1:0]         axil_rresp_i = 2'b00;
    logic               axil_rvalid_i = 1'b0;
    logic               axil_rready_o;

    int vectors = 0;
    int miscompares = 0;

    iob_iob2axil #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .iob_valid_i(iob_valid_i), .iob_addr_i(iob_addr_i), .iob_wdata_i(iob_wdata_i),
        .iob_wstrb_i(iob_wstrb_i), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
        .iob_rdata_o(iob_rdata_o), .iob_rready_i(iob_rready_i),
        .axil_awaddr_o(axil_awaddr_o), .axil_awvalid_o(axil_awvalid_o),
        .axil_awready_i(axil_awready_i), .axil_wdata_o(axil_wdata_o),
        .axil_wstrb_o(axil_wstrb_o), .axil_wvalid_o(axil_wvalid_o),
        .axil_wready_i(axil_wready_i), .axil_bresp_i(axil_bresp_i),
        .axil_bvalid_i(axil_bvalid_i), .axil_bready_o(axil_bready_o),
        .axil_araddr_o(axil_araddr_o), .axil_arvalid_o(axil_arvalid_o),
        .axil_arready_i(axil_arready_i), .axil_rdata_i(axil_rdata_i),
        .axil_rresp_i(axil_rresp_i), .axil_rvalid_i(axil_rvalid_i),
        .axil_rready_o(axil_rready_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        iob_valid_i    = 1'b0;
        iob_addr_i     = '0;
        iob_wdata_i    = '0;
        iob_wstrb_i    = '0;
        iob_rready_i   = 1'b0;
        axil_awready_i = 1'b0;
        axil_wready_i  = 1'b0;
        axil_bvalid_i  = 1'b0;
        axil_arready_i = 1'b0;
        axil_rvalid_i  = 1'b0;
        axil_rdata_i   = '0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        arst_i = 1'b1;
        step();
        step();
        flags = {iob_ready_o, iob_rvalid_o, axil_awvalid_o, axil_wvalid_o,
                 axil_bready_o, axil_arvalid_o, axil_rready_o, 1'b0};
        vectors++;
        if (flags !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected %b", flags, 8'h00);
        end
        vectors++;
        if ({axil_awaddr_o, axil_araddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h/%h/%h/%h/%h expected all zero",
                     axil_awaddr_o, axil_araddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o);
        end
        arst_i = 1'b0;
        step();
    endtask

    task automatic test_read_zero_wait();
        logic [3:0] f;
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h40;
        iob_wstrb_i    = '0;
        axil_arready_i = 1'b1;
        axil_rvalid_i  = 1'b1;
        axil_rdata_i   = 32'hDEADBEEF;
        step();
        f = {iob_ready_o, axil_arvalid_o, axil_rready_o, iob_rvalid_o};
        vectors++;
        if (f !== 4'b1100 || axil_araddr_o !== 21'h40 || axil_awvalid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_accept: got f=%b araddr=%h awvalid=%b expected f=1100 araddr=40 awvalid=0",
                     f, axil_araddr_o, axil_awvalid_o);
        end
        iob_valid_i = 1'b0;
        step();
        f = {iob_ready_o, axil_arvalid_o, axil_rready_o, iob_rvalid_o};
        vectors++;
        if (f !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL rd_rphase: got %b expected %b", f, 4'b0010);
        end
        step();
        f = {iob_ready_o, axil_arvalid_o, axil_rready_o, iob_rvalid_o};
        vectors++;
        if (f !== 4'b0001 || iob_rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL rd_resp: got f=%b rdata=%h expected f=0001 rdata=deadbeef", f, iob_rdata_o);
        end
        iob_rready_i = 1'b1;
        step();
        vectors++;
        if (iob_rvalid_o !== 1'b0 || iob_rdata_o !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL rd_done: got rvalid=%b rdata=%h expected rvalid=0 rdata=deadbeef",
                     iob_rvalid_o, iob_rdata_o);
        end
        clear_inputs();
    endtask

    task automatic test_write_skewed();
        logic [3:0] f;
        iob_valid_i = 1'b1;
        iob_addr_i  = 21'h10;
        iob_wdata_i = 32'h12345678;
        iob_wstrb_i = 4'hF;
        step();
        f = {iob_ready_o, axil_awvalid_o, axil_wvalid_o, axil_bready_o};
        vectors++;
        if (f !== 4'b1110 || axil_awaddr_o !== 21'h10 || axil_wdata_o !== 32'h12345678 ||
            axil_wstrb_o !== 4'hF || axil_arvalid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_accept: got f=%b awaddr=%h wdata=%h wstrb=%h arvalid=%b expected f=1110 10 12345678 f 0",
                     f, axil_awaddr_o, axil_wdata_o, axil_wstrb_o, axil_arvalid_o);
        end
        iob_valid_i    = 1'b0;
        axil_awready_i = 1'b1;
        step();
        axil_awready_i = 1'b0;
        f = {iob_ready_o, axil_awvalid_o, axil_wvalid_o, axil_bready_o};
        vectors++;
        if (f !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL wr_aw_first: got %b expected %b", f, 4'b0010);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            f = {iob_ready_o, axil_awvalid_o, axil_wvalid_o, axil_bready_o};
            vectors++;
            if (f !== 4'b0010) begin
                miscompares++;
                $display("[TB] FAIL wr_w_held[%0d]: got %b expected %b", i, f, 4'b0010);
            end
        end
        axil_wready_i = 1'b1;
        step();
        axil_wready_i = 1'b0;
        f = {iob_ready_o, axil_awvalid_o, axil_wvalid_o, axil_bready_o};
        vectors++;
        if (f !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL wr_bphase: got %b expected %b", f, 4'b0001);
        end
        step();
        vectors++;
        if (axil_bready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wr_b_wait: got %b expected %b", axil_bready_o, 1'b1);
        end
        axil_bvalid_i = 1'b1;
        step();
        axil_bvalid_i = 1'b0;
        f = {axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_rvalid_o};
        vectors++;
        if (f !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL wr_done: got %b expected %b", f, 4'b0000);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [2:0] f;
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h80;
        axil_arready_i = 1'b1;
        step();
        vectors++;
        if (iob_ready_o !== 1'b1 || axil_arvalid_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_accept: got ready=%b arvalid=%b expected 1 1", iob_ready_o, axil_arvalid_o);
        end
        // Keep a second request pending for the whole transaction.
        iob_addr_i = 21'h99;
        step();
        for (int i = 0; i < 5; i++) begin
            f = {iob_ready_o, axil_rready_o, iob_rvalid_o};
            vectors++;
            if (f !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL bp_rready[%0d]: got %b expected %b", i, f, 3'b010);
            end
            if (i == 4) begin
                axil_rvalid_i = 1'b1;
                axil_rdata_i  = 32'hCAFEF00D;
            end
            step();
        end
        axil_rvalid_i = 1'b0;
        axil_rdata_i  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            f = {iob_ready_o, axil_rready_o, iob_rvalid_o};
            vectors++;
            if (f !== 3'b001 || iob_rdata_o !== 32'hCAFEF00D) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got f=%b rdata=%h expected f=001 rdata=cafef00d",
                         i, f, iob_rdata_o);
            end
            if (i < 3) step();
        end
        iob_valid_i  = 1'b0;
        iob_rready_i = 1'b1;
        step();
        iob_rready_i = 1'b0;
        f = {iob_ready_o, axil_rready_o, iob_rvalid_o};
        vectors++;
        if (f !== 3'b000 || axil_arvalid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_done: got f=%b arvalid=%b expected f=000 arvalid=0", f, axil_arvalid_o);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic wr_busy, rd_busy;
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h20;
        iob_wdata_i    = 32'hA5A5A5A5;
        iob_wstrb_i    = 4'h3;
        axil_awready_i = 1'b1;
        axil_wready_i  = 1'b1;
        axil_bvalid_i  = 1'b1;
        axil_arready_i = 1'b1;
        axil_rvalid_i  = 1'b1;
        axil_rdata_i   = 32'h0BADF00D;
        iob_rready_i   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            wr_busy = axil_awvalid_o | axil_wvalid_o | axil_bready_o;
            rd_busy = axil_arvalid_o | axil_rready_o | iob_rvalid_o;
            vectors++;
            if (wr_busy && rd_busy) begin
                miscompares++;
                $display("[TB] FAIL b2b_overlap[%0d]: got wr=%b rd=%b expected no overlap", i, wr_busy, rd_busy);
            end
            if (iob_ready_o) begin
                pulses++;
                if (pulses == 1) begin
                    iob_addr_i  = 21'h24;
                    iob_wstrb_i = '0;
                end else begin
                    iob_valid_i = 1'b0;
                end
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_pulses: got %0d expected %0d", pulses, 2);
        end
        vectors++;
        if (iob_rdata_o !== 32'h0BADF00D || axil_wdata_o !== 32'hA5A5A5A5 || axil_araddr_o !== 21'h24) begin
            miscompares++;
            $display("[TB] FAIL b2b_data: got rdata=%h wdata=%h araddr=%h expected 0badf00d a5a5a5a5 24",
                     iob_rdata_o, axil_wdata_o, axil_araddr_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h30;
        iob_wdata_i    = 32'h00000077;
        iob_wstrb_i    = 4'h1;
        axil_awready_i = 1'b1;
        axil_wready_i  = 1'b1;
        step();
        iob_valid_i = 1'b0;
        step();
        vectors++;
        if (axil_bready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_in_wb: got bready=%b expected 1", axil_bready_o);
        end
        clear_inputs();
        arst_i = 1'b1;
        #1;
        vectors++;
        if ({axil_bready_o, axil_awvalid_o, axil_wvalid_o, iob_ready_o, iob_rvalid_o,
             axil_awaddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got bready=%b awaddr=%h wdata=%h wstrb=%h rdata=%h expected all zero",
                     axil_bready_o, axil_awaddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o);
        end
        step();
        arst_i = 1'b0;
        step();
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h44;
        axil_arready_i = 1'b1;
        axil_rvalid_i  = 1'b1;
        axil_rdata_i   = 32'h55AA55AA;
        step();
        vectors++;
        if (iob_ready_o !== 1'b1 || axil_arvalid_o !== 1'b1 || axil_araddr_o !== 21'h44) begin
            miscompares++;
            $display("[TB] FAIL rst_next_accept: got ready=%b arvalid=%b araddr=%h expected 1 1 44",
                     iob_ready_o, axil_arvalid_o, axil_araddr_o);
        end
        iob_valid_i = 1'b0;
        step();
        step();
        vectors++;
        if (iob_rvalid_o !== 1'b1 || iob_rdata_o !== 32'h55AA55AA) begin
            miscompares++;
            $display("[TB] FAIL rst_next_resp: got rvalid=%b rdata=%h expected 1 55aa55aa", iob_rvalid_o, iob_rdata_o);
        end
        iob_rready_i = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_cke();
        logic [2:0] f;
        iob_valid_i    = 1'b1;
        iob_addr_i     = 21'h50;
        axil_arready_i = 1'b1;
        step();
        iob_valid_i = 1'b0;
        step();
        vectors++;
        if (axil_rready_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cke_in_rr: got rready=%b expected 1", axil_rready_o);
        end
        cke_i         = 1'b0;
        axil_rvalid_i = 1'b1;
        axil_rdata_i  = 32'h13579BDF;
        for (int i = 0; i < 3; i++) begin
            step();
            f = {iob_ready_o, axil_rready_o, iob_rvalid_o};
            vectors++;
            if (f !== 3'b010 || iob_rdata_o !== 32'h55AA55AA) begin
                miscompares++;
                $display("[TB] FAIL cke_frozen[%0d]: got f=%b rdata=%h expected f=010 rdata=55aa55aa",
                         i, f, iob_rdata_o);
            end
        end
        cke_i = 1'b1;
        step();
        f = {iob_ready_o, axil_rready_o, iob_rvalid_o};
        vectors++;
        if (f !== 3'b001 || iob_rdata_o !== 32'h13579BDF) begin
            miscompares++;
            $display("[TB] FAIL cke_resume: got f=%b rdata=%h expected f=001 rdata=13579bdf", f, iob_rdata_o);
        end
        iob_rready_i = 1'b1;
        step();
        vectors++;
        if (iob_rvalid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cke_done: got rvalid=%b expected 0", iob_rvalid_o);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_read_zero_wait();
        test_write_skewed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_cke();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
